// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating an MCP3008-style 8-channel 10-bit ADC, oversampled on fpga_clk.
// Optional feature macro ADC_TEST_PATTERN_EN: replies {ch_sel, frame counter} instead of sample_data.
module spi_adc_responder #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              fpga_clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SS1,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  output logic [CH_W-1:0]   ch_sel,
  output logic              sgl_diff,
  output logic              sample_req,
  input  logic [DATA_W-1:0] sample_data,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_ST = 3'd1;
  localparam logic [2:0] S_CFG     = 3'd2;
  localparam logic [2:0] S_SAMPLE  = 3'd3;
  localparam logic [2:0] S_NULL    = 3'd4;
  localparam logic [2:0] S_DATA    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise_c, sck_fall_c, ss_rise_c;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   cfg_q, cfg_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] latch_val_c;
  logic              armed_q, armed_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              sgl_diff_q, sgl_diff_d;
  logic              sample_req_q, sample_req_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_abort_q, frame_abort_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise_c = sck_s & ~sck_prev_q;
  assign sck_fall_c = ~sck_s & sck_prev_q;
  assign ss_rise_c  = ss_s & ~ss_prev_q;

`ifdef ADC_TEST_PATTERN_EN
  localparam int unsigned FC_W = DATA_W - CH_W;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              unused_sample_c;

  assign unused_sample_c = ^sample_data;
  assign latch_val_c     = {ch_sel_q, frame_cnt_q};
  assign frame_cnt_d     = frame_cnt_q + FC_W'(frame_done_d);

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end
`else
  assign latch_val_c = sample_data;
`endif

  // Next-state and output decode; an SS1 rise or SS1 high overrides any SCK edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cfg_d         = cfg_q;
    shift_d       = shift_q;
    miso_d        = miso_q;
    ch_sel_d      = ch_sel_q;
    sgl_diff_d    = sgl_diff_q;
    sample_req_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    armed_d       = armed_q | ss_s;
    miso_oe_d     = ~ss_s;

    if (ss_rise_c) begin
      state_d       = S_IDLE;
      miso_d        = 1'b0;
      frame_abort_d = state_q inside {S_CFG, S_SAMPLE, S_NULL, S_DATA};
    end else if (ss_s) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) state_d = S_WAIT_ST;
        end
        S_WAIT_ST: begin
          if (sck_rise_c && mosi_s) begin
            state_d = S_CFG;
            cnt_d   = '0;
          end
        end
        S_CFG: begin
          if (sck_rise_c) begin
            cfg_d = {cfg_q[CH_W-2:0], mosi_s};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CH_W)) begin
              sgl_diff_d   = cfg_q[CH_W-1];
              ch_sel_d     = {cfg_q[CH_W-2:0], mosi_s};
              sample_req_d = 1'b1;
              state_d      = S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (sck_fall_c) begin
            shift_d = latch_val_c;
            miso_d  = 1'b0;
            state_d = S_NULL;
          end
        end
        S_NULL: begin
          if (sck_fall_c) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = CNT_W'(1);
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (sck_fall_c) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              frame_done_d = 1'b1;
              state_d      = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (sck_fall_c) miso_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      sck_sync_q    <= '0;
      ss_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sck_prev_q    <= 1'b0;
      ss_prev_q     <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cfg_q         <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      ch_sel_q      <= '0;
      sgl_diff_q    <= 1'b0;
      sample_req_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      ss_sync_q     <= {ss_sync_q[SYNC_STAGES-2:0], SS1};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_prev_q    <= sck_s;
      ss_prev_q     <= ss_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_q         <= cfg_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      ch_sel_q      <= ch_sel_d;
      sgl_diff_q    <= sgl_diff_d;
      sample_req_q  <= sample_req_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign MISO        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign ch_sel      = ch_sel_q;
  assign sgl_diff    = sgl_diff_q;
  assign sample_req  = sample_req_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: table-driven frames, hand sequences for reset/SS1-high, random frames vs a model.
module tb_spi_adc_responder;

  localparam int HALF = 4;

  logic       fpga_clk = 1'b0;
  logic       rst, SCK, SS1, MOSI;
  logic       MISO, miso_oe, sgl_diff, sample_req, frame_done, frame_abort;
  logic [2:0] ch_sel;
  logic [9:0] sample_data;

  int total = 0;
  int bad   = 0;
  int n_req = 0, n_done = 0, n_abort = 0;

  logic [2:0] m_ch;
  logic       m_sgl;
  logic [6:0] m_cnt;

  typedef struct {
    int         zeros;
    logic       sgl;
    logic [2:0] ch;
    logic [9:0] smp;
    int         nrise;
    logic [9:0] exp_word;
    int         exp_req;
    int         exp_done;
    int         exp_abort;
    logic [2:0] exp_ch;
    logic       exp_sgl;
  } vec_t;

  spi_adc_responder dut (
    .fpga_clk(fpga_clk), .rst(rst), .SCK(SCK), .SS1(SS1), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .ch_sel(ch_sel), .sgl_diff(sgl_diff),
    .sample_req(sample_req), .sample_data(sample_data),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 fpga_clk = ~fpga_clk;

  always @(negedge fpga_clk) begin
    if (sample_req)  n_req++;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int z, logic s, logic [2:0] c, logic [9:0] d, int n,
                              logic [9:0] w, int rq, int dn, int ab, logic [2:0] ec, logic es);
    vec_t v;
    v.zeros = z; v.sgl = s; v.ch = c; v.smp = d; v.nrise = n;
    v.exp_word = w; v.exp_req = rq; v.exp_done = dn; v.exp_abort = ab;
    v.exp_ch = ec; v.exp_sgl = es;
    return v;
  endfunction

  function automatic logic cmd_bit(vec_t v, int r);
    logic [2:0] t;
    if (r < v.zeros) return 1'b0;
    if (r == v.zeros) return 1'b1;
    if (r == v.zeros + 1) return v.sgl;
    if (r <= v.zeros + 4) begin
      t = v.ch >> (v.zeros + 4 - r);
      return t[0];
    end
    return 1'b0;
  endfunction

  // Frame outcome from the protocol rules: which pulses fire and what the master reads.
  task automatic model_fill(inout vec_t v);
    int k;
    logic [9:0] s, mask;
    v.exp_req   = (v.nrise >= v.zeros + 5) ? 1 : 0;
    v.exp_done  = (v.nrise >= v.zeros + 15) ? 1 : 0;
    v.exp_abort = (v.nrise >= v.zeros + 1 && v.nrise <= v.zeros + 14) ? 1 : 0;
    v.exp_ch    = (v.exp_req != 0) ? v.ch : m_ch;
    v.exp_sgl   = (v.exp_req != 0) ? v.sgl : m_sgl;
`ifdef ADC_TEST_PATTERN_EN
    s = {v.ch, m_cnt};
`else
    s = v.smp;
`endif
    k = v.nrise - (v.zeros + 6);
    if (k < 0) k = 0;
    if (k > 10) k = 10;
    mask = 10'h3FF << (10 - k);
    v.exp_word = s & mask;
  endtask

  task automatic sck_bit(input logic m, output logic seen);
    MOSI = m;
    repeat (HALF) @(negedge fpga_clk);
    seen = MISO;
    SCK = 1'b1;
    repeat (HALF) @(negedge fpga_clk);
    SCK = 1'b0;
  endtask

  task automatic run_check(input vec_t v, input string tag);
    logic [63:0] rd, other;
    logic [9:0]  w;
    logic        oe;
    int r0, d0, a0;
    r0 = n_req; d0 = n_done; a0 = n_abort;
    rd = '0;
    sample_data = ~v.smp;
    SS1 = 1'b0;
    repeat (6) @(negedge fpga_clk);
    oe = miso_oe;
    for (int r = 0; r < v.nrise; r++) begin
      MOSI = cmd_bit(v, r);
      repeat (HALF) @(negedge fpga_clk);
      rd[r] = MISO;
      SCK = 1'b1;
      repeat (HALF) @(negedge fpga_clk);
      if (r == v.zeros + 4) sample_data = v.smp;
      SCK = 1'b0;
    end
    MOSI = 1'b0;
    repeat (HALF) @(negedge fpga_clk);
    SS1 = 1'b1;
    repeat (8) @(negedge fpga_clk);

    w = '0;
    other = rd;
    for (int k = 0; k < 10; k++) begin
      if (v.zeros + 6 + k < v.nrise) begin
        w[9-k] = rd[v.zeros + 6 + k];
        other[v.zeros + 6 + k] = 1'b0;
      end
    end
    chk({tag, "_word"},     64'(w), 64'(v.exp_word));
    chk({tag, "_nulls"},    other, 64'd0);
    chk({tag, "_req"},      64'(n_req - r0), 64'(v.exp_req));
    chk({tag, "_done"},     64'(n_done - d0), 64'(v.exp_done));
    chk({tag, "_abort"},    64'(n_abort - a0), 64'(v.exp_abort));
    chk({tag, "_ch"},       64'(ch_sel), 64'(v.exp_ch));
    chk({tag, "_sgl"},      64'(sgl_diff), 64'(v.exp_sgl));
    chk({tag, "_oe_act"},   64'(oe), 64'd1);
    chk({tag, "_idle_out"}, 64'({MISO, miso_oe}), 64'd0);
    m_ch  = v.exp_ch;
    m_sgl = v.exp_sgl;
    m_cnt = m_cnt + 7'(v.exp_done);
  endtask

  vec_t tbl[$];
  vec_t v;
  logic seen;
  int   r0;

  initial begin
    rst = 1'b1; SCK = 1'b0; SS1 = 1'b0; MOSI = 1'b0; sample_data = '0;
    m_ch = '0; m_sgl = 1'b0; m_cnt = '0;
    repeat (3) @(negedge fpga_clk);
    chk("reset_outs", 64'({MISO, miso_oe, ch_sel, sgl_diff, sample_req, frame_done, frame_abort}), 64'd0);
    rst = 1'b0;

    // SS1 held low since reset: the block is not armed and must ignore this frame
    run_check(mk(0, 1'b1, 3'd5, 10'h3FF, 16, 10'h000, 0, 0, 0, 3'd0, 1'b0), "prearm");

`ifdef ADC_TEST_PATTERN_EN
    tbl.push_back(mk(0, 1'b1, 3'd3, 10'h2A5, 16, 10'h180, 1, 1, 0, 3'd3, 1'b1));
    tbl.push_back(mk(0, 1'b1, 3'd3, 10'h0F0, 16, 10'h181, 1, 1, 0, 3'd3, 1'b1));
    tbl.push_back(mk(0, 1'b1, 3'd3, 10'h3FF, 16, 10'h182, 1, 1, 0, 3'd3, 1'b1));
`else
    tbl.push_back(mk(7, 1'b1, 3'd1, 10'h2A5, 23, 10'h2A5, 1, 1, 0, 3'd1, 1'b1));
    tbl.push_back(mk(0, 1'b1, 3'd7, 10'h3FF, 24, 10'h3FF, 1, 1, 0, 3'd7, 1'b1));
    tbl.push_back(mk(2, 1'b0, 3'd4, 10'h1B6, 13, 10'h1A0, 1, 0, 1, 3'd4, 1'b0));
    tbl.push_back(mk(1, 1'b1, 3'd2, 10'h155, 17, 10'h155, 1, 1, 0, 3'd2, 1'b1));
`endif
    foreach (tbl[i]) run_check(tbl[i], $sformatf("tbl%0d", i));

    // SCK activity with SS1 high is ignored
    r0 = n_req;
    for (int i = 0; i < 20; i++) begin
      sck_bit(1'b1, seen);
      chk("ss_high_miso_oe", 64'({seen, miso_oe}), 64'd0);
    end
    chk("ss_high_req", 64'(n_req - r0), 64'd0);

    for (int i = 0; i < 16; i++) begin
      v = mk(int'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), 10'($urandom),
             0, '0, 0, 0, 0, '0, 1'b0);
      v.nrise = int'($urandom_range(0, 20)) + v.zeros;
      model_fill(v);
      run_check(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted mid-frame while SCK toggles
    sample_data = 10'h3FF;
    SS1 = 1'b0;
    repeat (6) @(negedge fpga_clk);
    v = mk(0, 1'b1, 3'd5, 10'h3FF, 0, '0, 0, 0, 0, '0, 1'b0);
    for (int r = 0; r < 10; r++) sck_bit(cmd_bit(v, r), seen);
    chk("pre_rst_ch", 64'(ch_sel), 64'd5);
    SCK = 1'b1;
    @(negedge fpga_clk);
    #2 rst = 1'b1;
    #1 chk("mid_rst_outs", 64'({MISO, miso_oe, ch_sel, sgl_diff, sample_req, frame_done, frame_abort}), 64'd0);
    SCK = 1'b0;
    for (int i = 0; i < 3; i++) sck_bit(1'b0, seen);
    SS1 = 1'b1;
    repeat (6) @(negedge fpga_clk);
    rst = 1'b0;
    m_ch = '0; m_sgl = 1'b0; m_cnt = '0;
    repeat (8) @(negedge fpga_clk);
    chk("post_rst_outs", 64'({MISO, miso_oe, ch_sel, sgl_diff}), 64'd0);
    v = mk(0, 1'b0, 3'd6, 10'h26B, 16, '0, 0, 0, 0, '0, 1'b0);
    model_fill(v);
    run_check(v, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
